// File: rtl/weight_accumulator_pkg.sv
// rtl/weight_accumulator_pkg.sv - shared constants and state encoding for the neuron datapath
package weight_accumulator_pkg;

    localparam int          NEURONS_DEF = 10;
    localparam int          ID_W_DEF    = 4;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/Addition_Subtraction.sv
// rtl/Addition_Subtraction.sv - combinational FP32 add/sub, round-to-nearest-even, subnormals flushed to zero
module Addition_Subtraction
    import weight_accumulator_pkg::*;
(
    input  logic [31:0] i_a_operand,
    input  logic [31:0] i_b_operand,
    input  logic        i_add_bar_sub,
    output logic        o_exception,
    output logic [31:0] o_result
);

    logic        w_b_sign;
    logic        w_a_big;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_exp_diff;
    logic [23:0] w_big_man;
    logic [23:0] w_small_man;
    logic [49:0] w_small_sh;
    logic [26:0] w_big_ext;
    logic [26:0] w_small_ext;
    logic        w_sub;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic [9:0]  w_exp;
    logic        w_rnd_up;
    logic [24:0] w_man_rnd;
    logic [9:0]  w_exp_rnd;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    assign o_exception = (&i_a_operand[30:23]) | (&i_b_operand[30:23]);

    always_comb begin
        w_b_sign    = i_b_operand[31] ^ i_add_bar_sub;
        w_a_big     = i_a_operand[30:0] >= i_b_operand[30:0];
        w_big       = w_a_big ? i_a_operand : {w_b_sign, i_b_operand[30:0]};
        w_small     = w_a_big ? {w_b_sign, i_b_operand[30:0]} : i_a_operand;
        w_exp_diff  = w_big[30:23] - w_small[30:23];
        w_big_man   = (w_big[30:23] == 8'd0) ? 24'd0 : {1'b1, w_big[22:0]};
        w_small_man = (w_small[30:23] == 8'd0) ? 24'd0 : {1'b1, w_small[22:0]};
        // Aligned small operand keeps guard, round and a sticky OR of everything shifted out
        w_small_sh  = {w_small_man, 26'd0} >> w_exp_diff;
        w_big_ext   = {w_big_man, 3'b000};
        w_small_ext = {w_small_sh[49:24], |w_small_sh[23:0]};
        w_sub       = w_big[31] ^ w_small[31];
        w_sum       = w_sub ? ({1'b0, w_big_ext} - {1'b0, w_small_ext})
                            : ({1'b0, w_big_ext} + {1'b0, w_small_ext});
        w_lz        = lzc27(w_sum[26:0]);
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = {2'b00, w_big[30:23]} + 10'd1;
        end else begin
            w_norm = w_sum[26:0] << w_lz;
            w_exp  = {2'b00, w_big[30:23]} - {5'd0, w_lz};
        end
        w_rnd_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_man_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
        w_exp_rnd = w_man_rnd[24] ? (w_exp + 10'd1) : w_exp;

        if ((w_sum == '0) || (!w_sum[27] && ({5'd0, w_lz} >= {2'b00, w_big[30:23]}))) begin
            o_result = FP_ZERO;
        end else if (w_exp_rnd >= 10'd255) begin
            o_result = {w_big[31], 8'hFF, 23'd0};
        end else begin
            o_result = {w_big[31], w_exp_rnd[7:0], w_man_rnd[24] ? w_man_rnd[23:1] : w_man_rnd[22:0]};
        end
    end

endmodule

// File: rtl/weight_accumulator.sv
// rtl/weight_accumulator.sv - per-neuron FP32 weight sums, drained in id order at timestep end
module weight_accumulator
    import weight_accumulator_pkg::*;
#(
    parameter int NEURONS = NEURONS_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            wgt_valid,
    output logic            wgt_ready,
    input  logic [ID_W-1:0] wgt_neuron_id,
    input  logic [31:0]     wgt_value,
    input  logic            timestep_end,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_neuron_id,
    output logic [31:0]     out_weight,
    output logic            out_last,
    output logic            busy,
    output logic            err_bad_id,
    output logic            err_fp_exc,
    output logic            err_overrun
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NEURONS - 1);

    state_t          r_state;
    logic [31:0]     r_acc [NEURONS];
    logic [ID_W-1:0] r_out_id;
    logic [31:0]     r_out_weight;
    logic            r_out_last;
    logic            r_err_bad_id;
    logic            r_err_fp_exc;
    logic            r_err_overrun;

    logic            w_accept;
    logic            w_id_ok;
    logic            w_write;
    logic [ID_W-1:0] w_rd_id;
    logic [31:0]     w_acc_rd;
    logic [31:0]     w_sum;
    logic            w_exc;
    logic [ID_W-1:0] w_next_id;

    assign w_accept  = wgt_valid && (r_state == ACCUM);
    assign w_id_ok   = wgt_neuron_id <= LAST_ID;
    assign w_write   = w_accept && w_id_ok;
    assign w_rd_id   = w_id_ok ? wgt_neuron_id : '0;
    assign w_acc_rd  = r_acc[w_rd_id];
    assign w_next_id = r_out_id + ID_W'(1);

    Addition_Subtraction u_add (
        .i_a_operand   (w_acc_rd),
        .i_b_operand   (wgt_value),
        .i_add_bar_sub (1'b0),
        .o_exception   (w_exc),
        .o_result      (w_sum)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= ACCUM;
            for (int i = 0; i < NEURONS; i++) r_acc[i] <= FP_ZERO;
            r_out_id      <= '0;
            r_out_weight  <= FP_ZERO;
            r_out_last    <= 1'b0;
            r_err_bad_id  <= 1'b0;
            r_err_fp_exc  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_accept && !w_id_ok) r_err_bad_id <= 1'b1;
            if (w_write) begin
                r_acc[w_rd_id] <= w_sum;
                if (w_exc) r_err_fp_exc <= 1'b1;
            end
            case (r_state)
                ACCUM: begin
                    if (timestep_end) begin
                        r_state    <= DRAIN;
                        r_out_id   <= '0;
                        // Forward a same-cycle write to entry 0 so it shows in the first output
                        r_out_weight <= (w_write && (w_rd_id == '0)) ? w_sum : r_acc[0];
                        r_out_last <= (LAST_ID == '0);
                    end
                end
                DRAIN: begin
                    if (timestep_end) r_err_overrun <= 1'b1;
                    if (out_ready) begin
                        if (r_out_last) begin
                            for (int i = 0; i < NEURONS; i++) r_acc[i] <= FP_ZERO;
                            r_state      <= ACCUM;
                            r_out_id     <= '0;
                            r_out_weight <= FP_ZERO;
                            r_out_last   <= 1'b0;
                        end else begin
                            r_out_id     <= w_next_id;
                            r_out_weight <= r_acc[w_next_id];
                            r_out_last   <= (w_next_id == LAST_ID);
                        end
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign wgt_ready     = (r_state == ACCUM);
    assign out_valid     = (r_state == DRAIN);
    assign busy          = (r_state == DRAIN);
    assign out_neuron_id = r_out_id;
    assign out_weight    = r_out_weight;
    assign out_last      = r_out_last;
    assign err_bad_id    = r_err_bad_id;
    assign err_fp_exc    = r_err_fp_exc;
    assign err_overrun   = r_err_overrun;

endmodule

// File: tb/tb_weight_accumulator.sv
// tb/tb_weight_accumulator.sv - self-checking bench for weight_accumulator
module tb_weight_accumulator;
    import weight_accumulator_pkg::*;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        wgt_valid = 1'b0;
    logic        wgt_ready;
    logic [3:0]  wgt_neuron_id = '0;
    logic [31:0] wgt_value = '0;
    logic        timestep_end = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_neuron_id;
    logic [31:0] out_weight;
    logic        out_last;
    logic        busy;
    logic        err_bad_id;
    logic        err_fp_exc;
    logic        err_overrun;

    weight_accumulator dut (
        .CLK(CLK), .reset(reset),
        .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .wgt_neuron_id(wgt_neuron_id), .wgt_value(wgt_value),
        .timestep_end(timestep_end),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_neuron_id(out_neuron_id), .out_weight(out_weight), .out_last(out_last),
        .busy(busy), .err_bad_id(err_bad_id), .err_fp_exc(err_fp_exc), .err_overrun(err_overrun)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_acc [10];
    logic [31:0] m_exp [10];
    bit          m_bad = 0, m_fpx = 0, m_ovr = 0;

    typedef struct {
        bit          vld;
        logic [3:0]  id;
        logic [31:0] w;
        bit          te;
        bit          exp_bad;
    } ev_t;
    ev_t         ev_tab [6];
    logic [31:0] exp_tab [2][10];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value h/2 as FP32; exact for the small half-integers used here
    function automatic logic [31:0] enc(input int h);
        int          m;
        int          p;
        logic [31:0] r;
        if (h == 0) return 32'h0;
        m = (h < 0) ? -h : h;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        r[31]    = (h < 0);
        r[30:23] = 8'(126 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_raw(input logic [3:0] id, input logic [31:0] w, input bit te);
        chk1("wgt_ready_on_send", wgt_ready, 1'b1);
        wgt_valid = 1'b1; wgt_neuron_id = id; wgt_value = w; timestep_end = te;
        step();
        wgt_valid = 1'b0; timestep_end = 1'b0;
    endtask

    task automatic send_h(input logic [3:0] id, input int h, input bit te);
        send_raw(id, enc(h), te);
        if (id < 10) m_acc[id] += h;
        else m_bad = 1;
    endtask

    task automatic pulse_te();
        timestep_end = 1'b1;
        step();
        timestep_end = 1'b0;
    endtask

    task automatic load_exp();
        for (int i = 0; i < 10; i++) m_exp[i] = enc(m_acc[i]);
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic drain(input int mode, input int ovr_at, input int stop_at);
        int hs = 0;
        int cyc = 0;
        bit rdy;
        bit ovr_done = 0;
        int limit = (stop_at > 0) ? stop_at : 10;
        while (hs < limit && cyc < 200) begin
            chk1("drain_valid", out_valid, 1'b1);
            chk1("drain_busy", busy, 1'b1);
            chk1("drain_wgt_ready", wgt_ready, 1'b0);
            chk32("drain_id", 32'(out_neuron_id), 32'(hs));
            chk32("drain_weight", out_weight, m_exp[hs]);
            chk1("drain_last", out_last, hs == 9);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom % 2);
            endcase
            out_ready = rdy;
            if (!ovr_done && hs == ovr_at) begin
                timestep_end = 1'b1;
                ovr_done = 1;
                m_ovr = 1;
            end
            step();
            timestep_end = 1'b0;
            out_ready = 1'b0;
            cyc++;
            if (rdy) hs++;
        end
        chk32("drain_handshakes", 32'(hs), 32'(limit));
        if (stop_at <= 0) begin
            chk1("post_valid", out_valid, 1'b0);
            chk1("post_busy", busy, 1'b0);
            chk1("post_wgt_ready", wgt_ready, 1'b1);
            chk1("post_last", out_last, 1'b0);
            chk1("err_bad_id", err_bad_id, m_bad);
            chk1("err_fp_exc", err_fp_exc, m_fpx);
            chk1("err_overrun", err_overrun, m_ovr);
            step();
            chk1("drain_no_repeat", out_valid, 1'b0);
            for (int i = 0; i < 10; i++) m_acc[i] = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n_ev;
        int h;

        ev_tab[0] = '{1'b1, 4'd2, 32'h3F800000, 1'b0, 1'b0};
        ev_tab[1] = '{1'b1, 4'd2, 32'h40000000, 1'b0, 1'b0};
        ev_tab[2] = '{1'b1, 4'd2, 32'h3F000000, 1'b0, 1'b0};
        ev_tab[3] = '{1'b0, 4'd0, 32'h00000000, 1'b1, 1'b0};
        ev_tab[4] = '{1'b1, 4'd0, 32'h3FC00000, 1'b0, 1'b0};
        ev_tab[5] = '{1'b1, 4'd9, 32'h40400000, 1'b1, 1'b0};
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 10; i++) exp_tab[t][i] = 32'h0;
        exp_tab[0][2] = 32'h40600000;
        exp_tab[1][0] = 32'h3FC00000;
        exp_tab[1][9] = 32'h40400000;
        for (int i = 0; i < 10; i++) m_acc[i] = 0;

        step();
        step();
        chk1("rst_wgt_ready", wgt_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk32("rst_out_id", 32'(out_neuron_id), 32'h0);
        chk32("rst_out_weight", out_weight, FP_ZERO);
        chk1("rst_err_bad_id", err_bad_id, 1'b0);
        chk1("rst_err_fp_exc", err_fp_exc, 1'b0);
        chk1("rst_err_overrun", err_overrun, 1'b0);
        reset = 1'b0;
        step();

        k = 0;
        for (int r = 0; r < 6; r++) begin
            if (ev_tab[r].vld) send_raw(ev_tab[r].id, ev_tab[r].w, ev_tab[r].te);
            else if (ev_tab[r].te) pulse_te();
            chk1("tab_err_bad_id", err_bad_id, ev_tab[r].exp_bad);
            if (ev_tab[r].te) begin
                for (int i = 0; i < 10; i++) m_exp[i] = exp_tab[k][i];
                k++;
                drain(0, -1, -1);
            end
        end

        send_h(4'd1, 3, 1'b0);
        send_h(4'd7, -5, 1'b0);
        send_h(4'd7, 2, 1'b0);
        pulse_te();
        load_exp();
        drain(1, -1, -1);

        send_raw(4'd12, FP_ONE, 1'b0);
        m_bad = 1;
        chk1("bad_id_flag", err_bad_id, 1'b1);
        chk1("bad_id_ready", wgt_ready, 1'b1);
        send_h(4'd4, 5, 1'b0);
        pulse_te();
        load_exp();
        drain(0, 3, -1);

        for (int ts = 0; ts < 4; ts++) begin
            n_ev = int'($urandom_range(20, 5));
            for (int e = 0; e < n_ev; e++) begin
                if ($urandom % 4 == 0) step();
                h = int'($urandom_range(31, 0)) - 16;
                if (h >= 0) h++;
                send_h(4'($urandom_range(11, 0)), h, (e == n_ev - 1) && ($urandom % 2 == 1));
            end
            if (timestep_end == 1'b0 && out_valid == 1'b0) pulse_te();
            load_exp();
            drain(2, -1, -1);
        end

        send_h(4'd0, 3, 1'b0);
        send_h(4'd2, -4, 1'b0);
        send_raw(4'd5, 32'h7F800000, 1'b0);
        m_fpx = 1;
        chk1("fp_exc_flag", err_fp_exc, 1'b1);
        pulse_te();
        load_exp();
        drain(0, -1, 4);
        reset = 1'b1;
        step();
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_wgt_ready", wgt_ready, 1'b1);
        chk1("abort_err_fp_exc", err_fp_exc, 1'b0);
        chk1("abort_err_bad_id", err_bad_id, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) m_acc[i] = 0;
        m_bad = 0; m_fpx = 0; m_ovr = 0;
        step();
        chk1("abort_idle_valid", out_valid, 1'b0);
        pulse_te();
        load_exp();
        drain(0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_accumulator.md
Name: weight_accumulator

Overview:
Upstream stage of the per-neuron potential adder. It accepts synaptic weight events (target neuron id plus IEEE-754 single weight) during a timestep and sums them per neuron in FP32. At timestep end it drains one accumulated input weight per neuron, in id order, to the potential adder over a valid/ready handshake. It then clears all sums for the next timestep.

Parameters:
NEURONS, 10, number of neurons served; accumulator entries 0..NEURONS-1
ID_W, 4, width of neuron id fields; must satisfy 2^ID_W >= NEURONS

Ports:
CLK  in  1  clock; all state updates on posedge CLK
reset  in  1  synchronous, active-high reset
wgt_valid  in  1  weight event present
wgt_ready  out  1  block accepts weight events
wgt_neuron_id  in  ID_W  target neuron of the event
wgt_value  in  32  FP32 synaptic weight
timestep_end  in  1  single-cycle pulse closing the current timestep
out_valid  out  1  out_weight/out_neuron_id valid
out_ready  in  1  potential adder consumes the output
out_neuron_id  out  ID_W  neuron the output belongs to
out_weight  out  32  FP32 summed input weight, feeds input_weight of the adder
out_last  out  1  high with the entry for neuron NEURONS-1
busy  out  1  high while draining
err_bad_id  out  1  sticky: an event carried id >= NEURONS
err_fp_exc  out  1  sticky: FP adder raised Exception on an accepted event
err_overrun  out  1  sticky: timestep_end arrived while draining

Behaviour:
- Reset, sampled synchronously:
  - state=ACCUM, all acc[i]=32'h00000000, drain index=0.
  - out_valid=0, out_last=0, busy=0, out_neuron_id=0, out_weight=0, all err flags=0.
  - wgt_ready=1 in the first cycle after reset.
  - Reset asserted mid-drain aborts the drain; nothing is emitted afterwards.
- States: ACCUM, DRAIN.
- ACCUM:
  - wgt_ready=1.
  - Accept when wgt_valid&&wgt_ready, then acc[id] <= fp_add(acc[id], wgt_value) at that edge. The add is combinational, giving one-cycle accept-to-update latency.
  - Back-to-back events to the same id need no stall, since the read-modify-write completes each cycle.
  - id >= NEURONS: event consumed, no acc change, err_bad_id set.
  - Adder Exception on an accepted event: the result is still written and err_fp_exc is set.
  - timestep_end: move to DRAIN next cycle. An event accepted in the same cycle is included in that timestep's sum.
- DRAIN:
  - wgt_ready=0, busy=1.
  - out_valid=1, out_neuron_id=index, out_weight=acc[index], out_last=(index==NEURONS-1).
  - On out_valid&&out_ready, index increments.
  - Without out_ready, all outputs are held stable (no change while valid and stalled).
  - On the last handshake: every acc cleared to +0.0, index=0, state=ACCUM, out_valid=0, busy=0. wgt_ready=1 the next cycle.
  - timestep_end during DRAIN is ignored and sets err_overrun.
- Drain latency: the first out_valid appears 1 cycle after timestep_end is sampled. The minimum drain is NEURONS cycles with out_ready tied high.
- An unused neuron outputs +0.0 (32'h00000000).
- err flags clear only on reset.

Decomposition:
- Shared package holds the FP32 constants FP_ZERO=32'h00000000 and FP_ONE=32'h3F800000, the state encoding (ACCUM=1'b0, DRAIN=1'b1), and the NEURONS/ID_W defaults. The potential adder and the decay stage use the same package.
- Sub-module: a single instance of the existing Addition_Subtraction (operation bit 1'b0) for the read-modify-write add.
- The accumulator bank stays inline as a NEURONS x 32 register array; no further split.

Test Plan:
- After reset: 3 events to id 2 with 3F800000, 40000000, 3F000000, then timestep_end, out_ready=1 -> 10 outputs in order 0..9. id2=40600000 (3.5); all others 00000000; out_last only on id 9; the next timestep starts with acc 0.
- Events to id 0 (3FC00000) and id 9 (40400000) interleaved with one same-cycle timestep_end on the id 9 event -> out_weight id0=3FC00000, id9=40400000.
- Drain with out_ready toggling 1,0,0,1... -> out_weight/out_neuron_id stable during stalls, no entry skipped or repeated, exactly 10 handshakes.
- Event with id 12 (wgt 3F800000) -> err_bad_id=1 sticky, all sums unchanged, wgt_ready still 1.
- timestep_end pulsed while draining -> err_overrun=1; the drain completes normally with a single pass.
- Reset asserted after 4 drained entries -> out_valid=0 next cycle, all acc 0, state ACCUM, and a following timestep produces only 00000000 outputs.
